// File: rtl/miter_misr_checker_pkg.sv
// miter_pkg: shared state encoding, default MISR constants and saturating increment
package miter_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [15:0] DEF_POLY = 16'hB400;
    localparam logic [15:0] DEF_SEED = 16'hFFFF;

    // w is the live counter width; the value sticks at its all-ones ceiling
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max;
        max = (w >= 32) ? '1 : (32'd1 << w) - 32'd1;
        return (v == max) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/miter_misr_checker_if.sv
// miter_misr_checker_if: run control, beat stream and result bundle of the miter checker
interface miter_misr_checker_if #(
    parameter int NCH   = 7,
    parameter int SIG_W = 16,
    parameter int CNT_W = 16
);
    logic             start;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [NCH-1:0]   out_a;
    logic [NCH-1:0]   out_b;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] first_idx;
    logic [NCH-1:0]   first_mask;
    logic [SIG_W-1:0] sig_a;
    logic [SIG_W-1:0] sig_b;

    modport master (
        output start, len, in_valid, out_a, out_b,
        input  in_ready, busy, done, pass, err_cnt, first_idx, first_mask, sig_a, sig_b
    );

    modport slave (
        input  start, len, in_valid, out_a, out_b,
        output in_ready, busy, done, pass, err_cnt, first_idx, first_mask, sig_a, sig_b
    );
endinterface

// File: rtl/miter_misr_checker_misr_lfsr.sv
// misr_lfsr: Galois MISR folding an NCH-bit vector into a SIG_W-bit signature per enabled cycle
module misr_lfsr #(
    parameter int               SIG_W = 16,
    parameter int               NCH   = 7,
    parameter logic [SIG_W-1:0] POLY  = 16'hB400,
    parameter logic [SIG_W-1:0] SEED  = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [NCH-1:0]   din,
    output logic [SIG_W-1:0] sig
);
    logic [SIG_W-1:0] r_sig;

    always_ff @(posedge clk) begin
        if (rst || load) r_sig <= SEED;
        else if (en) r_sig <= (r_sig >> 1) ^ (r_sig[0] ? POLY : '0) ^ SIG_W'(din);
    end

    assign sig = r_sig;
endmodule

// File: rtl/miter_misr_checker.sv
// miter_misr_checker: registered A^B miter with first-mismatch log, saturating error count
// and per-side MISR signatures over a run of len beats
module miter_misr_checker import miter_pkg::*; #(
    parameter int               NCH   = 7,
    parameter int               SIG_W = 16,
    parameter int               CNT_W = 16,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0] SEED  = SIG_W'(DEF_SEED)
) (
    input logic                  clk,
    input logic                  rst,
    miter_misr_checker_if.slave  io_bus
);
    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_len, r_cnt, r_idx_q, r_err, r_first_idx;
    logic [NCH-1:0]   r_a_q, r_b_q, r_first_mask;
    logic             r_v_q;
    logic             w_start, w_ready, w_accept, w_last;
    logic [NCH-1:0]   w_mask;

    assign w_start  = io_bus.start && (r_state == IDLE || r_state == DONE);
    assign w_ready  = (r_state == RUN) && (r_cnt < r_len);
    assign w_accept = io_bus.in_valid && w_ready;
    assign w_last   = r_cnt == r_len - CNT_W'(1);
    assign w_mask   = r_a_q ^ r_b_q;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_start) w_next = (io_bus.len == '0) ? DONE : RUN;
        else if (r_state == RUN && w_accept && w_last) w_next = DRAIN;
        else if (r_state == DRAIN) w_next = DONE;
    end

    // Stage 1 captures the accepted beat; stage 2 scores it one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len        <= '0;
            r_cnt        <= '0;
            r_idx_q      <= '0;
            r_a_q        <= '0;
            r_b_q        <= '0;
            r_v_q        <= 1'b0;
            r_err        <= '0;
            r_first_idx  <= '0;
            r_first_mask <= '0;
        end else if (w_start) begin
            r_len        <= io_bus.len;
            r_cnt        <= '0;
            r_v_q        <= 1'b0;
            r_err        <= '0;
            r_first_idx  <= '0;
            r_first_mask <= '0;
        end else begin
            r_v_q <= w_accept;
            if (w_accept) begin
                r_a_q   <= io_bus.out_a;
                r_b_q   <= io_bus.out_b;
                r_idx_q <= r_cnt;
                r_cnt   <= r_cnt + CNT_W'(1);
            end
            if (r_v_q && w_mask != '0) begin
                r_err <= CNT_W'(sat_inc(32'(r_err), CNT_W));
                if (r_err == '0) begin
                    r_first_idx  <= r_idx_q;
                    r_first_mask <= w_mask;
                end
            end
        end
    end

    misr_lfsr #(.SIG_W(SIG_W), .NCH(NCH), .POLY(POLY), .SEED(SEED)) u_misr_a (
        .clk(clk), .rst(rst), .load(w_start), .en(r_v_q), .din(r_a_q), .sig(io_bus.sig_a)
    );

    misr_lfsr #(.SIG_W(SIG_W), .NCH(NCH), .POLY(POLY), .SEED(SEED)) u_misr_b (
        .clk(clk), .rst(rst), .load(w_start), .en(r_v_q), .din(r_b_q), .sig(io_bus.sig_b)
    );

    assign io_bus.in_ready   = w_ready;
    assign io_bus.busy       = (r_state == RUN) || (r_state == DRAIN);
    assign io_bus.done       = r_state == DONE;
    assign io_bus.pass       = (r_state == DONE) && (r_err == '0);
    assign io_bus.err_cnt    = r_err;
    assign io_bus.first_idx  = r_first_idx;
    assign io_bus.first_mask = r_first_mask;
endmodule

// File: tb/tb_miter_misr_checker.sv
// tb_miter_misr_checker: directed vectors against a default instance and a CNT_W=4 instance
module tb_miter_misr_checker;
    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    miter_misr_checker_if #(.NCH(7), .SIG_W(16), .CNT_W(16)) m_if ();
    miter_misr_checker_if #(.NCH(7), .SIG_W(16), .CNT_W(4))  s_if ();

    miter_misr_checker #(.CNT_W(16)) u_dut (.clk(clk), .rst(rst), .io_bus(m_if));
    miter_misr_checker #(.CNT_W(4))  u_sat (.clk(clk), .rst(rst), .io_bus(s_if));

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [6:0] d);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000) ^ {9'b0, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_run(input logic [15:0] n);
        m_if.len   = n;
        m_if.start = 1'b1;
        tick();
        m_if.start = 1'b0;
    endtask

    task automatic send(input logic [6:0] a, input logic [6:0] b);
        chk("send_ready", m_if.in_ready, 1);
        m_if.in_valid = 1'b1;
        m_if.out_a    = a;
        m_if.out_b    = b;
        tick();
        m_if.in_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] ea, eb;
        logic [6:0]  a, b;
        rst = 1'b1;
        m_if.start = 0; m_if.len = 0; m_if.in_valid = 0; m_if.out_a = 0; m_if.out_b = 0;
        s_if.start = 0; s_if.len = 0; s_if.in_valid = 0; s_if.out_a = 0; s_if.out_b = 0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("rst_busy", m_if.busy, 0);
        chk("rst_ready", m_if.in_ready, 0);
        chk("rst_done", m_if.done, 0);
        chk("rst_pass", m_if.pass, 0);
        chk("rst_err", m_if.err_cnt, 0);
        chk("rst_sig_a", m_if.sig_a, 16'hFFFF);
        chk("rst_sig_b", m_if.sig_b, 16'hFFFF);

        // single zero beat
        start_run(1);
        chk("z_busy", m_if.busy, 1);
        send(7'h00, 7'h00);
        chk("z_drain_done", m_if.done, 0);
        chk("z_drain_busy", m_if.busy, 1);
        chk("z_drain_ready", m_if.in_ready, 0);
        tick();
        chk("z_done", m_if.done, 1);
        chk("z_pass", m_if.pass, 1);
        chk("z_sig_a", m_if.sig_a, 16'hCBFF);
        chk("z_sig_b", m_if.sig_b, 16'hCBFF);

        // single mismatch at beat 2
        start_run(4);
        send(7'h00, 7'h00);
        send(7'h00, 7'h00);
        send(7'h15, 7'h11);
        send(7'h00, 7'h00);
        tick();
        chk("mm_done", m_if.done, 1);
        chk("mm_err", m_if.err_cnt, 1);
        chk("mm_idx", m_if.first_idx, 2);
        chk("mm_mask", m_if.first_mask, 7'h04);
        chk("mm_pass", m_if.pass, 0);
        chk("mm_sig_a", m_if.sig_a, 16'h6E75);
        chk("mm_sig_b", m_if.sig_b, 16'h6E77);

        // backpressure with mismatches at beats 3, 7, 9
        start_run(10);
        ea = 16'hFFFF; eb = 16'hFFFF;
        for (int i = 0; i < 10; i++) begin
            tick();
            a = 7'(i * 9 + 5);
            b = a ^ ((i == 3) ? 7'h41 : (i == 7) ? 7'h22 : (i == 9) ? 7'h01 : 7'h00);
            ea = misr_step(ea, a);
            eb = misr_step(eb, b);
            send(a, b);
        end
        chk("bp_ready_drop", m_if.in_ready, 0);
        tick();
        chk("bp_done", m_if.done, 1);
        chk("bp_err", m_if.err_cnt, 3);
        chk("bp_idx", m_if.first_idx, 3);
        chk("bp_mask", m_if.first_mask, 7'h41);
        chk("bp_sig_a", m_if.sig_a, ea);
        chk("bp_sig_b", m_if.sig_b, eb);

        // zero-length run
        start_run(0);
        chk("l0_done", m_if.done, 1);
        chk("l0_pass", m_if.pass, 1);
        chk("l0_busy", m_if.busy, 0);
        chk("l0_err", m_if.err_cnt, 0);
        chk("l0_sig_a", m_if.sig_a, 16'hFFFF);

        // start during RUN and at DONE entry are both ignored
        start_run(3);
        send(7'h01, 7'h01);
        m_if.start = 1'b1;
        m_if.len   = 16'd7;
        send(7'h02, 7'h02);
        m_if.start = 1'b0;
        send(7'h03, 7'h03);
        chk("ig_ready_drop", m_if.in_ready, 0);
        m_if.start = 1'b1;
        m_if.len   = 16'd2;
        tick();
        m_if.start = 1'b0;
        chk("ig_done", m_if.done, 1);
        tick();
        chk("ig_done_hold", m_if.done, 1);
        chk("ig_busy", m_if.busy, 0);
        chk("ig_err", m_if.err_cnt, 0);
        chk("ig_sig_a", m_if.sig_a, misr_step(misr_step(misr_step(16'hFFFF, 7'h01), 7'h02), 7'h03));

        // reset on the 3rd beat of a len=5 run
        start_run(5);
        send(7'h01, 7'h02);
        send(7'h03, 7'h03);
        m_if.in_valid = 1'b1;
        m_if.out_a = 7'h05;
        m_if.out_b = 7'h04;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_if.in_valid = 1'b0;
        chk("mr_busy", m_if.busy, 0);
        chk("mr_done", m_if.done, 0);
        chk("mr_ready", m_if.in_ready, 0);
        chk("mr_err", m_if.err_cnt, 0);
        chk("mr_mask", m_if.first_mask, 0);
        chk("mr_sig_a", m_if.sig_a, 16'hFFFF);

        // CNT_W=4 instance, 15 mismatching beats
        s_if.len   = 4'd15;
        s_if.start = 1'b1;
        tick();
        s_if.start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            s_if.in_valid = 1'b1;
            s_if.out_a = 7'(i);
            s_if.out_b = ~7'(i);
            tick();
        end
        s_if.in_valid = 1'b0;
        chk("sat_ready_drop", s_if.in_ready, 0);
        tick();
        chk("sat_done", s_if.done, 1);
        chk("sat_err", s_if.err_cnt, 4'hF);
        chk("sat_idx", s_if.first_idx, 0);
        chk("sat_pass", s_if.pass, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
